cmp_layer_ctrl: RTL and testbench
=================================

Name: cmp_layer_ctrl

Overview:
Sequencer for the SIZE x SIZE sparse outer-product compute layer. On start it clears the layer accumulators and streams k_len weight/pixel vector pairs from the operand buffers into the layer. It waits for the layer pipeline to settle, then drains the psum array one row per valid/ready handshake to the writeback path. Between vectors and when idle it drives zero operands, so the units' zero-skip logic suppresses all updates.

Parameters:
DATA_WID, 16, operand element width
SIZE, 8, layer dimension (vectors per side, rows drained)
K_WID, 10, width of the step count k_len
ADDR_WID, 10, operand buffer address width
PIPE_LAT, 3, cycles from an operand at the layer inputs to its psum update being visible

Ports:
clock  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  begin tile; sampled only in IDLE
k_len  in  K_WID  number of outer-product steps; latched at start
w_base  in  ADDR_WID  first weight vector address; latched at start
p_base  in  ADDR_WID  first pixel vector address; latched at start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at tile completion
err  out  1  one-cycle pulse when start is given with k_len==0
buf_rd_en  out  1  operand buffer read strobe
w_addr  out  ADDR_WID  weight buffer read address
p_addr  out  ADDR_WID  pixel buffer read address
w_data  in  SIZE*DATA_WID  weight vector; valid 1 cycle after buf_rd_en
p_data  in  SIZE*DATA_WID  pixel vector; valid 1 cycle after buf_rd_en
acc_clr  out  1  accumulator clear to the layer
weights_out  out  SIZE*DATA_WID  layer weight inputs (registered)
pixels_out  out  SIZE*DATA_WID  layer pixel inputs (registered)
row_sel  out  $clog2(SIZE)  psum row selected by the external row mux
psum_row_in  in  SIZE*48  selected psum row (combinational from row_sel)
out_valid  out  1  drain data valid
out_ready  in  1  writeback ready
out_row  out  $clog2(SIZE)  row index of out_data
out_data  out  SIZE*48  drained row, equal to psum_row_in
perf_cycles  out  32  busy cycle count (see Optional Feature)
perf_zero_steps  out  K_WID  count of all-zero operand steps (see Optional Feature)

Behaviour:
- Reset, priority over everything, in any state:
  - state=IDLE.
  - All outputs 0, including weights_out, pixels_out, row_sel and the address registers.
  - An in-flight tile is abandoned: no done and no further reads.
- FSM states: IDLE, CLEAR, FETCH, FLUSH, DRAIN, DONE.
- IDLE:
  - start && k_len!=0: latch k_len, w_base and p_base, then go to CLEAR.
  - start && k_len==0: err=1 for 1 cycle and stay in IDLE.
- CLEAR (1 cycle): acc_clr=1, step counter i=0, then go to FETCH.
- FETCH (k_len cycles):
  - buf_rd_en=1, w_addr=w_base+i, p_addr=p_base+i, i++.
  - Address arithmetic is modulo 2^ADDR_WID (wraps).
  - Leave when i==k_len-1 is issued.
- Operand path: rd_v <= buf_rd_en. When rd_v=1, weights_out<=w_data and pixels_out<=p_data; otherwise both are driven to 0.
  - An operand reaches the layer 2 cycles after its address is issued.
  - Exactly k_len non-idle operand cycles occur, back to back.
- FLUSH: wait 2+PIPE_LAT cycles after the last FETCH cycle, then enter DRAIN with row r=0.
- DRAIN:
  - row_sel=r, out_row=r, out_valid=1, out_data=psum_row_in.
  - On out_valid&&out_ready: r++. After row SIZE-1 is accepted, go to DONE.
  - While out_ready=0, row_sel and out_row hold; out_data holds because the psums are quiescent.
- DONE (1 cycle): done=1, then go to IDLE. busy falls in the same cycle that IDLE is entered.
- start while busy: ignored, with no queueing.
- acc_clr is the only event that clears psums. Psums remain readable after done until the next start.

Optional Feature:
CMP_CTRL_PERF_EN
- Defined:
  - perf_cycles increments every cycle busy=1.
  - perf_zero_steps increments on each operand cycle where the w_data or p_data vector is entirely zero (a step skipped by the layer).
  - Both counters clear in CLEAR. perf_cycles saturates at all-ones.
  - Both hold their values in IDLE.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Basic: k_len=4, w_base=0x010, p_base=0x020, out_ready=1.
  - Addresses 0x010..0x013 / 0x020..0x023 on 4 consecutive cycles.
  - acc_clr occurs 1 cycle before the first read.
  - The 4 operand pairs appear at the layer 2 cycles after their reads.
  - 8 rows drain as out_row 0..7 on consecutive cycles, then done pulses once.
- k_len=0 with start -> err pulse, busy stays 0, no buf_rd_en.
- Backpressure: out_ready toggles 0,0,1 per row -> each row is held stable for 3 cycles; 24 drain cycles total; done only after row 7 is accepted.
- Wrap: w_base=0x3FE, k_len=4 -> w_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- start pulsed during FETCH with different bases -> ignored; the original tile completes unchanged.
- rst during FETCH (i=2) -> all outputs 0 next cycle, state IDLE, no done. A following start(k_len=1) runs cleanly and drains 8 rows.
- With CMP_CTRL_PERF_EN defined:
  - k_len=3, second weight vector all zero -> perf_zero_steps=1.
  - perf_cycles = 1+3+(2+PIPE_LAT)+8+1 = 18 with out_ready=1.

Source files
------------

// File: rtl/cmp_layer_ctrl.sv
// Sequencer for the SIZE x SIZE sparse outer-product layer: clear, operand fetch, flush, row drain.
// Define CMP_CTRL_PERF_EN to build the busy-cycle and zero-step performance counters.
module cmp_layer_ctrl #(
    parameter int unsigned DATA_WID = 16,
    parameter int unsigned SIZE     = 8,
    parameter int unsigned K_WID    = 10,
    parameter int unsigned ADDR_WID = 10,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_WID-1:0]         k_len,
    input  logic [ADDR_WID-1:0]      w_base,
    input  logic [ADDR_WID-1:0]      p_base,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     buf_rd_en,
    output logic [ADDR_WID-1:0]      w_addr,
    output logic [ADDR_WID-1:0]      p_addr,
    input  logic [SIZE*DATA_WID-1:0] w_data,
    input  logic [SIZE*DATA_WID-1:0] p_data,
    output logic                     acc_clr,
    output logic [SIZE*DATA_WID-1:0] weights_out,
    output logic [SIZE*DATA_WID-1:0] pixels_out,
    output logic [$clog2(SIZE)-1:0]  row_sel,
    input  logic [SIZE*48-1:0]       psum_row_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(SIZE)-1:0]  out_row,
    output logic [SIZE*48-1:0]       out_data,
    output logic [31:0]              perf_cycles,
    output logic [K_WID-1:0]         perf_zero_steps
);

    localparam int unsigned RowWid   = $clog2(SIZE);
    localparam int unsigned FlushCyc = 2 + PIPE_LAT;
    localparam int unsigned FlushWid = $clog2(FlushCyc + 1);
    localparam logic [RowWid-1:0]   LastRow   = RowWid'(SIZE - 1);
    localparam logic [FlushWid-1:0] LastFlush = FlushWid'(FlushCyc - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StFlush,
        StDrain,
        StDone
    } state_e;

    state_e              state_q;
    logic [K_WID-1:0]    k_len_q;
    logic [K_WID-1:0]    step_q;
    logic [ADDR_WID-1:0] w_base_q;
    logic [ADDR_WID-1:0] p_base_q;
    logic [FlushWid-1:0] flush_q;
    logic                rd_v_q;
    logic                start_ok;

    assign start_ok = (state_q == StIdle) && start && (k_len != '0);
    assign out_row  = row_sel;
    // Gated so the drain bus reads zero outside DRAIN, including under reset.
    assign out_data = out_valid ? psum_row_in : '0;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= StIdle;
            k_len_q   <= '0;
            step_q    <= '0;
            w_base_q  <= '0;
            p_base_q  <= '0;
            flush_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            acc_clr   <= 1'b0;
            buf_rd_en <= 1'b0;
            w_addr    <= '0;
            p_addr    <= '0;
            row_sel   <= '0;
            out_valid <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        k_len_q  <= k_len;
                        w_base_q <= w_base;
                        p_base_q <= p_base;
                        busy     <= 1'b1;
                        acc_clr  <= 1'b1;
                        state_q  <= StClear;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                StClear: begin
                    step_q    <= '0;
                    w_addr    <= w_base_q;
                    p_addr    <= p_base_q;
                    buf_rd_en <= 1'b1;
                    state_q   <= StFetch;
                end
                StFetch: begin
                    if (step_q == k_len_q - K_WID'(1)) begin
                        buf_rd_en <= 1'b0;
                        flush_q   <= '0;
                        state_q   <= StFlush;
                    end else begin
                        step_q <= step_q + K_WID'(1);
                        w_addr <= w_addr + ADDR_WID'(1);
                        p_addr <= p_addr + ADDR_WID'(1);
                    end
                end
                StFlush: begin
                    // Covers buffer latency, operand register and the layer pipeline.
                    if (flush_q == LastFlush) begin
                        row_sel   <= '0;
                        out_valid <= 1'b1;
                        state_q   <= StDrain;
                    end else begin
                        flush_q <= flush_q + FlushWid'(1);
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (row_sel == LastRow) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            row_sel <= row_sel + RowWid'(1);
                        end
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Idle cycles present zero operands so the units' zero-skip suppresses updates.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_v_q      <= 1'b0;
            weights_out <= '0;
            pixels_out  <= '0;
        end else begin
            rd_v_q      <= buf_rd_en;
            weights_out <= rd_v_q ? w_data : '0;
            pixels_out  <= rd_v_q ? p_data : '0;
        end
    end

`ifdef CMP_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            perf_cycles     <= '0;
            perf_zero_steps <= '0;
        end else if (start_ok) begin
            perf_cycles     <= '0;
            perf_zero_steps <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (rd_v_q && ((w_data == '0) || (p_data == '0))) begin
                perf_zero_steps <= perf_zero_steps + K_WID'(1);
            end
        end
    end
`else
    assign perf_cycles     = '0;
    assign perf_zero_steps = '0;
`endif

endmodule

// File: tb/tb_cmp_layer_ctrl.sv
// Bench for cmp_layer_ctrl: a tile-timeline model checked every cycle, plus directed literal checks.
module tb_cmp_layer_ctrl;

    localparam int DW    = 16;
    localparam int SZ    = 8;
    localparam int KW    = 10;
    localparam int AW    = 10;
    localparam int PL    = 3;
    localparam int VW    = SZ * DW;
    localparam int RDW   = SZ * 48;
    localparam int RB    = $clog2(SZ);
    localparam int AMASK = (1 << AW) - 1;

    logic           clock = 1'b0;
    logic           rst;
    logic           start;
    logic [KW-1:0]  k_len;
    logic [AW-1:0]  w_base;
    logic [AW-1:0]  p_base;
    logic           busy, done, err, buf_rd_en, acc_clr, out_valid;
    logic [AW-1:0]  w_addr, p_addr;
    logic [VW-1:0]  w_data = '0;
    logic [VW-1:0]  p_data = '0;
    logic [VW-1:0]  weights_out, pixels_out;
    logic [RB-1:0]  row_sel, out_row;
    logic [RDW-1:0] psum_row_in;
    logic           out_ready = 1'b1;
    logic [RDW-1:0] out_data;
    logic [31:0]    perf_cycles;
    logic [KW-1:0]  perf_zero_steps;

    cmp_layer_ctrl #(
        .DATA_WID(DW), .SIZE(SZ), .K_WID(KW), .ADDR_WID(AW), .PIPE_LAT(PL)
    ) dut (
        .clock(clock), .rst(rst), .start(start), .k_len(k_len), .w_base(w_base),
        .p_base(p_base), .busy(busy), .done(done), .err(err), .buf_rd_en(buf_rd_en),
        .w_addr(w_addr), .p_addr(p_addr), .w_data(w_data), .p_data(p_data),
        .acc_clr(acc_clr), .weights_out(weights_out), .pixels_out(pixels_out),
        .row_sel(row_sel), .psum_row_in(psum_row_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
        .perf_cycles(perf_cycles), .perf_zero_steps(perf_zero_steps)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int zero_w_addr = -1;
    int rmode = 0;
    int ph = 0;

    function automatic logic [VW-1:0] wvec(input int a);
        logic [VW-1:0] v;
        for (int l = 0; l < SZ; l++) v[l*DW +: DW] = DW'(a * 8 + l + 1);
        if (a == zero_w_addr) v = '0;
        return v;
    endfunction

    function automatic logic [VW-1:0] pvec(input int a);
        logic [VW-1:0] v;
        for (int l = 0; l < SZ; l++) v[l*DW +: DW] = DW'(a * 8 + l + 'h4001);
        return v;
    endfunction

    function automatic logic [RDW-1:0] prow(input int r);
        logic [RDW-1:0] v;
        for (int l = 0; l < SZ; l++) v[l*48 +: 48] = 48'((r + 1) * 4096 + l + 1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic lchk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Operand buffers: one-cycle read latency, junk when not reading.
    logic mem_rd;
    int   mem_wa, mem_pa;
    always @(posedge clock) begin
        mem_rd = buf_rd_en;
        mem_wa = int'(w_addr);
        mem_pa = int'(p_addr);
        #1;
        w_data = mem_rd ? wvec(mem_wa) : {SZ{16'hDEAD}};
        p_data = mem_rd ? pvec(mem_pa) : {SZ{16'hBEEF}};
    end

    always_comb psum_row_in = prow(int'(row_sel));

    // rmode 1: ready pattern 0,0,1 for each row offered.
    always @(posedge clock) begin
        #1;
        if (rmode == 0) begin
            out_ready = 1'b1;
        end else if (out_valid) begin
            out_ready = (ph == 2);
            ph = (ph == 2) ? 0 : ph + 1;
        end else begin
            out_ready = 1'b0;
            ph = 0;
        end
    end

    // Model: a tile is a timeline relative to its accept edge (rel=1 is the clear cycle).
    bit     m_active = 0;
    bit     m_err = 0;
    int     m_rel = 0, m_k = 0, m_wb = 0, m_pb = 0, m_rows = 0, m_zs = 0;
    longint m_pc = 0;

    always @(posedge clock) begin
        if (rst) begin
            m_active = 0;
            m_err = 0;
            m_pc = 0;
            m_zs = 0;
        end else begin
            m_err = 0;
            if (m_active) begin
                if (m_pc < 64'hFFFF_FFFF) m_pc++;
                if (m_rel >= 3 && m_rel < 3 + m_k &&
                    (wvec((m_wb + m_rel - 3) & AMASK) == '0 ||
                     pvec((m_pb + m_rel - 3) & AMASK) == '0)) m_zs++;
                if (m_rows == SZ) begin
                    m_active = 0;
                end else begin
                    if (m_rel >= m_k + 7 && out_ready) m_rows++;
                    m_rel++;
                end
            end else if (start) begin
                if (k_len != '0) begin
                    m_active = 1;
                    m_rel = 1;
                    m_k = int'(k_len);
                    m_wb = int'(w_base);
                    m_pb = int'(p_base);
                    m_rows = 0;
                    m_pc = 0;
                    m_zs = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus event logs for the directed checks.
    int cyc = 0;
    int wlog[$], plog[$];
    int done_cnt, err_cnt, busy_seen, drain_cyc, rows_acc;
    int acc_cyc, rd0_cyc, op0_cyc, done_cyc, last_acc_cyc;
    bit e_rd, e_lay, e_ov;

    always @(negedge clock) begin
        cyc++;
        e_rd  = m_active && m_rel >= 2 && m_rel < 2 + m_k;
        e_lay = m_active && m_rel >= 4 && m_rel < 4 + m_k;
        e_ov  = m_active && m_rel >= m_k + 7 && m_rows < SZ;
        chk("busy", 512'(busy), 512'(m_active));
        chk("acc_clr", 512'(acc_clr), 512'(m_active && m_rel == 1));
        chk("buf_rd_en", 512'(buf_rd_en), 512'(e_rd));
        if (e_rd) begin
            chk("w_addr", 512'(w_addr), 512'((m_wb + m_rel - 2) & AMASK));
            chk("p_addr", 512'(p_addr), 512'((m_pb + m_rel - 2) & AMASK));
        end
        chk("weights_out", 512'(weights_out), e_lay ? 512'(wvec((m_wb + m_rel - 4) & AMASK)) : '0);
        chk("pixels_out", 512'(pixels_out), e_lay ? 512'(pvec((m_pb + m_rel - 4) & AMASK)) : '0);
        chk("out_valid", 512'(out_valid), 512'(e_ov));
        if (e_ov) begin
            chk("row_sel", 512'(row_sel), 512'(m_rows));
            chk("out_row", 512'(out_row), 512'(m_rows));
        end
        chk("out_data", 512'(out_data), e_ov ? 512'(prow(m_rows)) : '0);
        chk("done", 512'(done), 512'(m_active && m_rows == SZ));
        chk("err", 512'(err), 512'(m_err));
`ifdef CMP_CTRL_PERF_EN
        chk("perf_cycles", 512'(perf_cycles), 512'(m_pc));
        chk("perf_zero_steps", 512'(perf_zero_steps), 512'(m_zs));
`else
        chk("perf_cycles", 512'(perf_cycles), '0);
        chk("perf_zero_steps", 512'(perf_zero_steps), '0);
`endif
        if (buf_rd_en) begin
            if (wlog.size() == 0) rd0_cyc = cyc;
            wlog.push_back(int'(w_addr));
            plog.push_back(int'(p_addr));
        end
        if (acc_clr) acc_cyc = cyc;
        if (weights_out != '0 && op0_cyc < 0) op0_cyc = cyc;
        if (out_valid) drain_cyc++;
        if (out_valid && out_ready) begin
            rows_acc++;
            last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (busy) busy_seen++;
    end

    task automatic clear_logs();
        wlog.delete();
        plog.delete();
        done_cnt = 0; err_cnt = 0; busy_seen = 0; drain_cyc = 0; rows_acc = 0;
        acc_cyc = -1; rd0_cyc = -1; op0_cyc = -1; done_cyc = -1; last_acc_cyc = -1;
    endtask

    task automatic do_start(input int k, input int wb, input int pb);
        start = 1'b1;
        k_len = KW'(k);
        w_base = AW'(wb);
        p_base = AW'(pb);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
        end
        idle(2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; w_base = '0; p_base = '0;
        clear_logs();
        idle(3);
        rst = 1'b0;
        @(negedge clock);
        lchk("reset_busy", int'(busy), 0);
        lchk("reset_w_addr", int'(w_addr), 0);
        chk("reset_weights", 512'(weights_out), '0);
        idle(1);

        // Basic tile
        clear_logs();
        do_start(4, 'h010, 'h020);
        wait_done("basic", 200);
        idle(3);
        lchk("basic_reads", wlog.size(), 4);
        for (int j = 0; j < 4 && j < wlog.size(); j++) begin
            lchk("basic_w_addr", wlog[j], 'h010 + j);
            lchk("basic_p_addr", plog[j], 'h020 + j);
        end
        lchk("basic_clr_lead", rd0_cyc - acc_cyc, 1);
        lchk("basic_op_lat", op0_cyc - rd0_cyc, 2);
        lchk("basic_drain_cycles", drain_cyc, 8);
        lchk("basic_done_count", done_cnt, 1);
        lchk("basic_done_time", done_cyc - acc_cyc, 18);

        // k_len == 0
        clear_logs();
        k_len = '0; start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(4);
        lchk("k0_err_count", err_cnt, 1);
        lchk("k0_busy_cycles", busy_seen, 0);
        lchk("k0_reads", wlog.size(), 0);

        // Backpressure 0,0,1 per row
        clear_logs();
        rmode = 1;
        do_start(2, 'h030, 'h031);
        wait_done("bp", 300);
        rmode = 0;
        idle(2);
        lchk("bp_drain_cycles", drain_cyc, 24);
        lchk("bp_rows", rows_acc, 8);
        lchk("bp_done_count", done_cnt, 1);
        lchk("bp_done_after_last", done_cyc - last_acc_cyc, 1);

        // Address wrap
        clear_logs();
        do_start(4, 'h3FE, 'h005);
        wait_done("wrap", 200);
        lchk("wrap_reads", wlog.size(), 4);
        if (wlog.size() == 4) begin
            lchk("wrap_a0", wlog[0], 'h3FE);
            lchk("wrap_a1", wlog[1], 'h3FF);
            lchk("wrap_a2", wlog[2], 'h000);
            lchk("wrap_a3", wlog[3], 'h001);
        end

        // Start during FETCH is ignored
        clear_logs();
        do_start(4, 'h040, 'h050);
        idle(1);
        do_start(6, 'h200, 'h300);
        wait_done("ignore", 200);
        idle(6);
        lchk("ignore_reads", wlog.size(), 4);
        if (wlog.size() == 4) begin
            lchk("ignore_w_last", wlog[3], 'h043);
            lchk("ignore_p_last", plog[3], 'h053);
        end
        lchk("ignore_done_count", done_cnt, 1);

        // Reset mid-FETCH
        clear_logs();
        do_start(8, 'h080, 'h090);
        idle(3);
        lchk("rst_pre_addr", int'(w_addr), 'h082);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clock);
        lchk("rst_rd_en", int'(buf_rd_en), 0);
        lchk("rst_busy", int'(busy), 0);
        lchk("rst_w_addr", int'(w_addr), 0);
        chk("rst_weights", 512'(weights_out), '0);
        idle(20);
        lchk("rst_no_done", done_cnt, 0);
        clear_logs();
        do_start(1, 'h0AA, 'h0BB);
        wait_done("post_rst", 200);
        lchk("post_rst_reads", wlog.size(), 1);
        lchk("post_rst_drain", drain_cyc, 8);

        // Zero-skip step (second weight vector all zero)
        clear_logs();
        zero_w_addr = 'h101;
        do_start(3, 'h100, 'h180);
        wait_done("perf", 200);
        idle(2);
`ifdef CMP_CTRL_PERF_EN
        lchk("perf_zero_steps_lit", int'(perf_zero_steps), 1);
        lchk("perf_cycles_lit", int'(perf_cycles), 18);
`endif
        zero_w_addr = -1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
